// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_subtractor
// Description : Computes A - B - BIN one 4-bit nibble per clock, using a 4-bit
//               carry-lookahead cell and a registered inter-nibble carry.
//               Optional macro SUB_OVERFLOW_DETECT_EN adds o_OVERFLOW.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor #(
  parameter int p_WIDTH = 16
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_START,
  input  logic [p_WIDTH-1:0] i_INPUT_A,
  input  logic [p_WIDTH-1:0] i_INPUT_B,
  input  logic               i_BIN,
  output logic               o_BUSY,
  output logic               o_DONE,
  output logic [p_WIDTH-1:0] o_RESULT,
`ifdef SUB_OVERFLOW_DETECT_EN
  output logic               o_BOUT,
  output logic               o_OVERFLOW
`else
  output logic               o_BOUT
`endif
);

  localparam int c_NIBBLES = p_WIDTH / 4;
  localparam int c_IDX_W   = $clog2(c_NIBBLES);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [p_WIDTH-1:0]   r_a;
  logic [p_WIDTH-1:0]   r_b;
  logic                 r_bin;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_carry;
  logic [p_WIDTH-1:0]   r_result;
  logic                 r_bout;

  logic                 w_accept;
  logic                 w_last;
  logic [p_WIDTH-1:0]   w_a_sh;
  logic [p_WIDTH-1:0]   w_b_sh;
  logic [3:0]           w_a_nib;
  logic [3:0]           w_b_nib;
  logic [3:0]           w_p;
  logic [3:0]           w_g;
  logic [3:0]           w_c;
  logic                 w_cin;
  logic [3:0]           w_sum;

  assign w_accept = i_START && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_idx == c_LAST);

  // Select the active nibble by shifting rather than a variable part-select.
  assign w_a_sh  = r_a >> {r_idx, 2'b00};
  assign w_b_sh  = r_b >> {r_idx, 2'b00};
  assign w_a_nib = w_a_sh[3:0];
  assign w_b_nib = w_b_sh[3:0];

  // Subtraction as A + ~B + carry; nibble 0 takes the inverted borrow-in.
  assign w_cin = (r_idx == '0) ? ~r_bin : r_carry;
  assign w_p   = w_a_nib ^ ~w_b_nib;
  assign w_g   = w_a_nib & ~w_b_nib;

  assign w_c[0] = w_g[0] | (w_p[0] & w_cin);
  assign w_c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cin);
  assign w_c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_cin);
  assign w_c[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cin);

  assign w_sum = w_p ^ {w_c[2:0], w_cin};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_START) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = i_START ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_a      <= '0;
      r_b      <= '0;
      r_bin    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= i_INPUT_A;
      r_b   <= i_INPUT_B;
      r_bin <= i_BIN;
      r_idx <= '0;
    end else if (r_state == S_CALC) begin
      r_idx   <= r_idx + 1'b1;
      r_carry <= w_c[3];
      for (int j = 0; j < c_NIBBLES; j++) begin
        if (r_idx == c_IDX_W'(j)) begin
          r_result[4*j +: 4] <= w_sum;
        end
      end
      if (w_last) begin
        r_bout <= ~w_c[3];
      end
    end
  end

`ifdef SUB_OVERFLOW_DETECT_EN
  logic r_overflow;

  // Carry into the MSB is w_c[2] of the top nibble.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_overflow <= 1'b0;
    end else if (!w_accept && r_state == S_CALC && w_last) begin
      r_overflow <= w_c[2] ^ w_c[3];
    end
  end

  assign o_OVERFLOW = r_overflow;
`endif

  assign o_BUSY   = (r_state == S_CALC);
  assign o_DONE   = (r_state == S_DONE);
  assign o_RESULT = r_result;
  assign o_BOUT   = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_subtractor
// Description : Directed and random checks of nibble_serial_subtractor (16 bit)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         bout;
`ifdef SUB_OVERFLOW_DETECT_EN
  logic         overflow;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  nibble_serial_subtractor #(.p_WIDTH(W)) dut (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_START    (start),
    .i_INPUT_A  (in_a),
    .i_INPUT_B  (in_b),
    .i_BIN      (bin),
    .o_BUSY     (busy),
    .o_DONE     (done),
    .o_RESULT   (result),
`ifdef SUB_OVERFLOW_DETECT_EN
    .o_BOUT     (bout),
    .o_OVERFLOW (overflow)
`else
    .o_BOUT     (bout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bi);
    int d;
    d = int'(a) - int'(b) - int'(bi);
    return W'(d);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, b, input logic bi);
    return int'(a) < int'(b) + int'(bi);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic bi);
    int sa, sb, d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb - int'(bi);
    return (d > 32767) || (d < -32768);
  endfunction

  // Drive a start at the current negedge; returns one negedge later.
  task automatic launch_now(input logic [W-1:0] a, b, input logic bi);
    in_a  = a;
    in_b  = b;
    bin   = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Runs one operation and checks it at the done cycle; stays on that negedge.
  task automatic run_op(input logic [W-1:0] a, b, input logic bi, input bit chain);
    int cnt;
    if (!chain) @(negedge clk);
    else chk("no_idle_gap_pre", {31'd0, busy}, 32'd0);
    launch_now(a, b, bi);
    chk("busy_in_calc", {31'd0, busy}, 32'd1);
    wait_done(cnt);
    chk("latency", cnt, 32'd4);
    chk("result", {16'd0, result}, {16'd0, ref_diff(a, b, bi)});
    chk("bout", {31'd0, bout}, {31'd0, ref_borrow(a, b, bi)});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef SUB_OVERFLOW_DETECT_EN
    chk("overflow", {31'd0, overflow}, {31'd0, ref_ovf(a, b, bi)});
`endif
  endtask

  task automatic post_hold(input logic [W-1:0] a, b, input logic bi);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_held", {16'd0, result}, {16'd0, ref_diff(a, b, bi)});
    chk("bout_held", {31'd0, bout}, {31'd0, ref_borrow(a, b, bi)});
  endtask

  initial begin
    logic [W-1:0] ra, rb, res_seen;
    logic         rbi;
    bit           chain;
    int           dones;

    rst_n = 1'b0;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_OVERFLOW_DETECT_EN
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
    rst_n = 1'b1;

    // Directed cases
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    chk("d1_result", {16'd0, result}, 32'h1000);
    post_hold(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    chk("d2_result", {16'd0, result}, 32'hFFFF);
    chk("d2_bout", {31'd0, bout}, 32'd1);
    post_hold(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    chk("d3_result", {16'd0, result}, 32'h7FFF);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b0);
    chk("d4_result", {16'd0, result}, 32'h0001);

    // Start pulsed mid-operation must be ignored
    @(negedge clk);
    launch_now(16'h0005, 16'h0003, 1'b1);
    @(negedge clk);
    in_a  = 16'hFFFF;
    in_b  = 16'h0000;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    res_seen = '0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dones++;
        res_seen = result;
      end
      @(negedge clk);
    end
    chk("midcalc_dones", dones, 32'd1);
    chk("midcalc_result", {16'd0, res_seen}, 32'h0001);

    // Reset before the second CALC edge aborts the operation
    launch_now(16'h1234, 16'h0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    chk("d5_result", {16'd0, result}, 32'h0000);
    chk("d5_bout", {31'd0, bout}, 32'd0);

    // Back-to-back start while in DONE
    run_op(16'h0010, 16'h0001, 1'b0, 1'b1);
    chk("b2b_result", {16'd0, result}, 32'h000F);
    post_hold(16'h0010, 16'h0001, 1'b0);

    // Random operations, some chained back-to-back
    chain = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
      rbi = 1'($urandom);
      run_op(ra, rb, rbi, chain);
      chain = 1'($urandom);
    end
    post_hold(ra, rb, rbi);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
